// File: rtl/hp_phase_if.sv
// Control/status bundle between a core sequencer and the hp35 two-phase generator.
// Optional per_cnt field present only when HP_PHASE_CNT_EN is defined.
interface hp_phase_if #(
  parameter int DIV_W  = 4,
  parameter int NPHASE = 4
);
  logic [DIV_W-1:0]  div_cfg;
  logic [DIV_W-1:0]  p1_cfg;
  logic [DIV_W-1:0]  p2_cfg;
  logic              run;
  logic              step;
  logic              resync;
  logic              phi1_n;
  logic              phi2_n;
  logic [NPHASE-1:0] t_state;
  logic              cyc_done;
  logic              busy;
  logic              cfg_err;
`ifdef HP_PHASE_CNT_EN
  logic [15:0]       per_cnt;
`endif

  modport master (
`ifdef HP_PHASE_CNT_EN
    input  per_cnt,
`endif
    output div_cfg, p1_cfg, p2_cfg, run, step, resync,
    input  phi1_n, phi2_n, t_state, cyc_done, busy, cfg_err
  );

  modport slave (
`ifdef HP_PHASE_CNT_EN
    output per_cnt,
`endif
    input  div_cfg, p1_cfg, p2_cfg, run, step, resync,
    output phi1_n, phi2_n, t_state, cyc_done, busy, cfg_err
  );
endinterface

// File: rtl/hp_phase_gen.sv
// Programmable non-overlapping phi1/phi2 generator with one-hot T-state ring, run/stop/step control.
// Define HP_PHASE_CNT_EN to add the per_cnt completed-period counter.
module hp_phase_gen #(
  parameter int DIV_W      = 4,
  parameter int NPHASE     = 4,
  parameter int RESYNC_IDX = 2,
  parameter int DEF_DIV    = 7,
  parameter int DEF_P1     = 5,
  parameter int DEF_P2     = 7
) (
  input  logic        osc_in,
  input  logic        cdiv_rst_n,
  hp_phase_if.slave   bus
);

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_STEP} state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  div_lat, p1_lat, p2_lat;
  logic              phi1_n_q, phi2_n_q, cyc_done_q, cfg_err_q;
  logic [NPHASE-1:0] t_state_q;
  logic              busy, wrap, reload, cfg_ok;

  assign cfg_ok = (bus.div_cfg != '0) && (bus.p1_cfg <= bus.div_cfg) &&
                  (bus.p2_cfg <= bus.div_cfg) && (bus.p1_cfg != bus.p2_cfg);

  always_ff @(posedge osc_in) begin
    if (!cdiv_rst_n) state <= ST_STOP;
    else             state <= state_nxt;
  end

  // run is only honoured at a wrap, so a dropped run always finishes its period
  always_comb begin
    state_nxt = state;
    case (state)
      ST_STOP: begin
        if (bus.run)       state_nxt = ST_RUN;
        else if (bus.step) state_nxt = ST_STEP;
      end
      ST_RUN:  if (wrap && !bus.run) state_nxt = ST_STOP;
      ST_STEP: if (wrap) state_nxt = ST_STOP;
      default: state_nxt = ST_STOP;
    endcase
  end

  always_comb begin
    busy   = (state != ST_STOP);
    wrap   = busy && (cnt == div_lat);
    reload = ((state == ST_STOP) && (bus.run || bus.step)) || wrap;
  end

  always_ff @(posedge osc_in) begin
    if (!cdiv_rst_n) begin
      cnt        <= '0;
      div_lat    <= DIV_W'(DEF_DIV);
      p1_lat     <= DIV_W'(DEF_P1);
      p2_lat     <= DIV_W'(DEF_P2);
      cfg_err_q  <= 1'b0;
      phi1_n_q   <= 1'b1;
      phi2_n_q   <= 1'b1;
      cyc_done_q <= 1'b0;
      t_state_q  <= NPHASE'(1);
    end else begin
      if (reload) begin
        if (cfg_ok) begin
          div_lat   <= bus.div_cfg;
          p1_lat    <= bus.p1_cfg;
          p2_lat    <= bus.p2_cfg;
          cfg_err_q <= 1'b0;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end
      if (busy) cnt <= wrap ? '0 : cnt + DIV_W'(1);
      cyc_done_q <= wrap;
      if (wrap) begin
        if (bus.resync) t_state_q <= NPHASE'(1) << RESYNC_IDX;
        else            t_state_q <= {t_state_q[NPHASE-2:0], t_state_q[NPHASE-1]};
      end
      // compared against the pre-wrap latch, so the strobe at cnt==div_lat survives entry to STOP
      phi1_n_q <= !(busy && (cnt == p1_lat));
      phi2_n_q <= !(busy && (cnt == p2_lat));
    end
  end

`ifdef HP_PHASE_CNT_EN
  logic [15:0] per_cnt_q;
  always_ff @(posedge osc_in) begin
    if (!cdiv_rst_n) per_cnt_q <= '0;
    else if (wrap)   per_cnt_q <= per_cnt_q + 16'd1;
  end
  assign bus.per_cnt = per_cnt_q;
`endif

  assign bus.phi1_n   = phi1_n_q;
  assign bus.phi2_n   = phi2_n_q;
  assign bus.t_state  = t_state_q;
  assign bus.cyc_done = cyc_done_q;
  assign bus.busy     = busy;
  assign bus.cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_hp_phase_gen.sv
// Scoreboard bench for hp_phase_gen: expected strobe/wrap events are queued per scenario
// and matched against observed events as the DUT emits them.
module tb_hp_phase_gen;

  typedef struct {
    int kind;  // 0 = phi1, 1 = phi2, 2 = cyc_done
    int cyc;
    int val;   // t_state after wrap for cyc_done
  } ev_t;

  logic osc_in = 1'b0;
  logic cdiv_rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  ev_t  exp_q[$];

  hp_phase_if #(.DIV_W(4), .NPHASE(4)) bus ();

  hp_phase_gen dut (
    .osc_in     (osc_in),
    .cdiv_rst_n (cdiv_rst_n),
    .bus        (bus)
  );

  always #5 osc_in = ~osc_in;
  always @(posedge osc_in) cyc <= cyc + 1;

  task automatic push_ev(input int kind, input int c, input int val);
    ev_t e;
    int  pos;
    e.kind = kind; e.cyc = c; e.val = val;
    pos = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].cyc * 4 + exp_q[i].kind > c * 4 + kind) begin
        pos = i;
        break;
      end
    end
    exp_q.insert(pos, e);
  endtask

  // one period starting with cnt=0 after edge s
  task automatic exp_period(input int s, input int dv, input int p1, input int p2, input int tn);
    push_ev(0, s + p1 + 1, 0);
    push_ev(1, s + p2 + 1, 0);
    push_ev(2, s + dv + 1, tn);
  endtask

  always @(negedge osc_in) begin
    for (int k = 0; k < 3; k++) begin
      logic hit;
      int   v;
      ev_t  e;
      hit = (k == 0) ? !bus.phi1_n : (k == 1) ? !bus.phi2_n : bus.cyc_done;
      v   = (k == 2) ? int'(bus.t_state) : 0;
      if (hit === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event kind=%0d cyc=%0d val=%0d (none expected)", k, cyc, v);
        end else begin
          e = exp_q.pop_front();
          if (e.kind !== k || e.cyc !== cyc || e.val !== v) begin
            errors++;
            $display("FAIL event_match got kind=%0d cyc=%0d val=%0d expected kind=%0d cyc=%0d val=%0d",
                     k, cyc, v, e.kind, e.cyc, e.val);
          end
        end
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge osc_in);
  endtask

  task automatic do_reset();
    cdiv_rst_n = 1'b0;
    bus.div_cfg = 4'd7; bus.p1_cfg = 4'd5; bus.p2_cfg = 4'd7;
    bus.run = 1'b0; bus.step = 1'b0; bus.resync = 1'b0;
    repeat (2) @(negedge osc_in);
    cdiv_rst_n = 1'b1;
    @(negedge osc_in);
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.phi1_n !== 1'b1)     begin errors++; $display("FAIL reset_phi1_n got %b want 1", bus.phi1_n); end
    checks++; if (bus.phi2_n !== 1'b1)     begin errors++; $display("FAIL reset_phi2_n got %b want 1", bus.phi2_n); end
    checks++; if (bus.t_state !== 4'b0001) begin errors++; $display("FAIL reset_t_state got %b want 0001", bus.t_state); end
    checks++; if (bus.cyc_done !== 1'b0)   begin errors++; $display("FAIL reset_cyc_done got %b want 0", bus.cyc_done); end
    checks++; if (bus.busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.cfg_err !== 1'b0)    begin errors++; $display("FAIL reset_cfg_err got %b want 0", bus.cfg_err); end
  endtask

  task automatic test_default_run();
    int a;
    int tseq[4] = '{2, 4, 8, 1};
    do_reset();
    bus.run = 1'b1; a = cyc + 1;
    for (int k = 0; k < 4; k++) exp_period(a + 8 * k, 7, 5, 7, tseq[k]);
    wait_until(a + 1);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL default_busy got %b want 1", bus.busy); end
    wait_until(a + 25); bus.run = 1'b0;
    wait_until(a + 32);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL default_stop got busy=%b want 0", bus.busy); end
    wait_until(a + 40);
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL default_missing got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_cfg_change();
    int a;
    do_reset();
    bus.run = 1'b1; a = cyc + 1;
    exp_period(a, 7, 5, 7, 2);
    exp_period(a + 8, 3, 0, 2, 4);
    exp_period(a + 12, 3, 0, 2, 8);
    wait_until(a + 3);
    bus.div_cfg = 4'd3; bus.p1_cfg = 4'd0; bus.p2_cfg = 4'd2;
    wait_until(a + 13); bus.run = 1'b0;
    wait_until(a + 24);
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL cfg_change_missing got %0d pending want 0", exp_q.size()); end
    checks++; if (bus.busy !== 1'b0)  begin errors++; $display("FAIL cfg_change_stop got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_cfg_err();
    int a;
    do_reset();
    bus.run = 1'b1; a = cyc + 1;
    exp_period(a, 7, 5, 7, 2);
    exp_period(a + 8, 7, 5, 7, 4);
    exp_period(a + 16, 7, 3, 1, 8);
    wait_until(a + 2); bus.p1_cfg = 4'd3; bus.p2_cfg = 4'd3;
    wait_until(a + 7);
    checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_before got %b want 0", bus.cfg_err); end
    wait_until(a + 8);
    checks++; if (bus.cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_set got %b want 1", bus.cfg_err); end
    wait_until(a + 10); bus.p2_cfg = 4'd1;
    wait_until(a + 15);
    checks++; if (bus.cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_held got %b want 1", bus.cfg_err); end
    wait_until(a + 16);
    checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_clear got %b want 0", bus.cfg_err); end
    wait_until(a + 17); bus.run = 1'b0;
    wait_until(a + 32);
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL cfg_err_missing got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_run_drop();
    int a;
    do_reset();
    bus.run = 1'b1; a = cyc + 1;
    exp_period(a, 7, 5, 7, 2);
    wait_until(a + 2); bus.run = 1'b0;
    wait_until(a + 7);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL run_drop_busy got %b want 1", bus.busy); end
    wait_until(a + 8);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL run_drop_idle got %b want 0", bus.busy); end
    wait_until(a + 24);
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL run_drop_missing got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_step();
    int a;
    do_reset();
    bus.step = 1'b1; a = cyc + 1;
    exp_period(a, 7, 5, 7, 2);
    @(negedge osc_in); bus.step = 1'b0;
    wait_until(a + 3); bus.step = 1'b1;
    @(negedge osc_in); bus.step = 1'b0;
    wait_until(a + 7);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL step_busy got %b want 1", bus.busy); end
    wait_until(a + 8);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL step_idle got %b want 0", bus.busy); end
    wait_until(a + 20);
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL step_missing got %0d pending want 0", exp_q.size()); end
    checks++; if (bus.busy !== 1'b0)  begin errors++; $display("FAIL step_requeued got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_resync();
    int a;
    do_reset();
    bus.run = 1'b1; a = cyc + 1;
    exp_period(a, 7, 5, 7, 4);
    exp_period(a + 8, 7, 5, 7, 8);
    wait_until(a + 7); bus.resync = 1'b1;
    wait_until(a + 8); bus.resync = 1'b0;
    wait_until(a + 9); bus.run = 1'b0;
    wait_until(a + 24);
    checks++; if (exp_q.size() !== 0)      begin errors++; $display("FAIL resync_missing got %0d pending want 0", exp_q.size()); end
    checks++; if (bus.t_state !== 4'b1000) begin errors++; $display("FAIL resync_final got %b want 1000", bus.t_state); end
  endtask

  task automatic test_reset_mid();
    int a;
    do_reset();
    bus.run = 1'b1; a = cyc + 1;
    wait_until(a + 5); cdiv_rst_n = 1'b0;
    wait_until(a + 6);
    checks++; if (bus.phi1_n !== 1'b1)     begin errors++; $display("FAIL rst_mid_phi1_n got %b want 1", bus.phi1_n); end
    checks++; if (bus.busy !== 1'b0)       begin errors++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
    checks++; if (bus.t_state !== 4'b0001) begin errors++; $display("FAIL rst_mid_t_state got %b want 0001", bus.t_state); end
    checks++; if (bus.cyc_done !== 1'b0)   begin errors++; $display("FAIL rst_mid_cyc_done got %b want 0", bus.cyc_done); end
    cdiv_rst_n = 1'b1; bus.run = 1'b0;
    wait_until(a + 16);
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rst_mid_pending got %0d want 0", exp_q.size()); end
  endtask

`ifdef HP_PHASE_CNT_EN
  task automatic test_per_cnt();
    int a;
    do_reset();
    checks++; if (bus.per_cnt !== 16'd0) begin errors++; $display("FAIL per_cnt_reset got %0d want 0", bus.per_cnt); end
    bus.run = 1'b1; a = cyc + 1;
    exp_period(a, 7, 5, 7, 2);
    exp_period(a + 8, 7, 5, 7, 4);
    exp_period(a + 16, 7, 5, 7, 8);
    wait_until(a + 17); bus.run = 1'b0;
    wait_until(a + 24);
    checks++; if (bus.per_cnt !== 16'd3) begin errors++; $display("FAIL per_cnt_24 got %0d want 3", bus.per_cnt); end
    wait_until(a + 32);
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL per_cnt_missing got %0d pending want 0", exp_q.size()); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_default_run();
    test_cfg_change();
    test_cfg_err();
    test_run_drop();
    test_step();
    test_resync();
    test_reset_mid();
`ifdef HP_PHASE_CNT_EN
    test_per_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
